r5p_bus_sig_reader: RTL and testbench

//  Bus initiator on the r5p load/store bus; the read-side counterpart of the rvmodel signature controller.
//  On start it reads every word in the half-open byte range [cfg_beg, cfg_end) from memory.
//  It returns the words in address order on a valid/ready stream for signature dump/compare logic.

---
 rtl/r5p_bus_pkg.sv | 14 +
 rtl/r5p_sync_fifo.sv | 49 ++++
 rtl/r5p_bus_sig_reader.sv | 107 ++++++++++
 tb/tb_r5p_bus_sig_reader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/r5p_bus_pkg.sv
// r5p_bus_pkg: shared types and helpers for the r5p load/store bus initiators
package r5p_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } sig_rd_state_t;

    function automatic int wstep(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/r5p_sync_fifo.sv
// r5p_sync_fifo: fall-through FIFO with occupancy count; a push into an empty FIFO is visible at once
module r5p_sync_fifo #(
    parameter int W = 33,
    parameter int D = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [W-1:0]       din,
    input  logic               pop,
    output logic               vld,
    output logic [W-1:0]       dout,
    output logic [$clog2(D):0] count
);

    localparam int PW = $clog2(D);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [D];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          empty;
    logic          wr;
    logic          rd;

    assign empty = count == '0;
    assign vld   = push || !empty;
    assign dout  = empty ? din : mem[rp];
    // a word that arrives into an empty FIFO and leaves in the same cycle is never stored
    assign wr    = push && !(empty && pop);
    assign rd    = pop && !empty;

    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr) wp <= wp + PW'(1);
            if (rd) rp <= rp + PW'(1);
            count <= count + CW'(wr) - CW'(rd);
        end
    end

endmodule

// File: rtl/r5p_bus_sig_reader.sv
// r5p_bus_sig_reader: reads the word range [cfg_beg, cfg_end) over the r5p bus
// and streams the words out in address order, flagging the last one
module r5p_bus_sig_reader
    import r5p_bus_pkg::*;
#(
    parameter int AW = 22,
    parameter int DW = 32,
    parameter int BW = DW / 8,
    parameter int FD = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] cfg_beg,
    input  logic [AW-1:0] cfg_end,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          bus_vld,
    output logic          bus_wen,
    output logic [AW-1:0] bus_adr,
    output logic [BW-1:0] bus_ben,
    output logic [DW-1:0] bus_wdt,
    input  logic [DW-1:0] bus_rdt,
    input  logic          bus_rdy,
    output logic          str_vld,
    output logic [DW-1:0] str_dat,
    output logic          str_lst,
    input  logic          str_rdy
);

    localparam int            CW   = $clog2(FD) + 1;
    localparam logic [AW-1:0] STEP = AW'(wstep(DW));

    sig_rd_state_t state;
    logic [AW-1:0] adr;
    logic [AW-1:0] last;
    logic          infl;
    logic          infl_lst;
    logic          hs;
    logic          pop;
    logic          bad;
    logic [CW-1:0] cnt;
    logic [DW:0]   fdat;

    assign bad     = ((cfg_beg | cfg_end) & AW'(BW - 1)) != '0 || cfg_end < cfg_beg;
    assign hs      = bus_vld && bus_rdy;
    assign pop     = str_vld && str_rdy;
    assign busy    = state != IDLE;
    // the in-flight read already owns a FIFO slot, so it is counted against the depth
    assign bus_vld = state == READ && cnt + CW'(infl) < CW'(FD);
    assign bus_wen = 1'b0;
    assign bus_adr = adr;
    assign bus_ben = '1;
    assign bus_wdt = '0;
    assign str_dat = fdat[DW-1:0];
    assign str_lst = str_vld && fdat[DW];

    r5p_sync_fifo #(
        .W (DW + 1),
        .D (FD)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (infl),
        .din   ({infl_lst, bus_rdt}),
        .pop   (pop),
        .vld   (str_vld),
        .dout  (fdat),
        .count (cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            adr      <= '0;
            last     <= '0;
            infl     <= 1'b0;
            infl_lst <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            infl     <= hs;
            infl_lst <= adr == last;
            done     <= 1'b0;
            err      <= 1'b0;
            if (state == IDLE && start) begin
                err  <= bad;
                done <= !bad && cfg_beg == cfg_end;
                if (!bad && cfg_beg != cfg_end) begin
                    state <= READ;
                    adr   <= cfg_beg;
                    last  <= cfg_end - STEP;
                end
            end
            if (hs) begin
                adr <= adr + STEP;
                if (adr == last) state <= DRAIN;
            end
            if (state == DRAIN && !infl && cnt == '0) begin
                state <= IDLE;
                done  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_r5p_bus_sig_reader.sv
// tb_r5p_bus_sig_reader: randomized scoreboard bench; expected words come from an
// address-to-data memory model expanded per requested range
module tb_r5p_bus_sig_reader;

    localparam int AW = 22;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int FD = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] cfg_beg = '0;
    logic [AW-1:0] cfg_end = '0;
    logic          start = 1'b0;
    logic          busy, done, err;
    logic          bus_vld, bus_wen;
    logic [AW-1:0] bus_adr;
    logic [BW-1:0] bus_ben;
    logic [DW-1:0] bus_wdt;
    logic [DW-1:0] bus_rdt = '0;
    logic          bus_rdy = 1'b0;
    logic          str_vld;
    logic [DW-1:0] str_dat;
    logic          str_lst;
    logic          str_rdy = 1'b0;

    r5p_bus_sig_reader #(.AW(AW), .DW(DW), .BW(BW), .FD(FD)) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_beg (cfg_beg),
        .cfg_end (cfg_end),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bus_vld (bus_vld),
        .bus_wen (bus_wen),
        .bus_adr (bus_adr),
        .bus_ben (bus_ben),
        .bus_wdt (bus_wdt),
        .bus_rdt (bus_rdt),
        .bus_rdy (bus_rdy),
        .str_vld (str_vld),
        .str_dat (str_dat),
        .str_lst (str_lst),
        .str_rdy (str_rdy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [DW:0] exp_q[$];
    int          mode = 0, hold = 0, cyc = 0;
    int          beats = 0, first_cyc = 0, last_cyc = 0;
    int          done_cnt = 0, err_cnt = 0, bvld_cnt = 0, svld_cnt = 0;
    int          hs_total = 0, beats_total = 0;
    logic          pend = 1'b0;
    logic [AW-1:0] pend_adr = '0;
    logic          prev_bstall = 1'b0;
    logic [AW-1:0] prev_badr = '0;
    logic          prev_sstall = 1'b0;
    logic [DW:0]   prev_sword = '0;
    logic [DW:0]   ex;

    function automatic logic [DW-1:0] mem_at(input logic [AW-1:0] a);
        return {10'h295, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_err"}, 64'(err), 0);
        chk({tag, "_bus_vld"}, 64'(bus_vld), 0);
        chk({tag, "_bus_adr"}, 64'(bus_adr), 0);
        chk({tag, "_str_vld"}, 64'(str_vld), 0);
        chk({tag, "_str_lst"}, 64'(str_lst), 0);
    endtask

    // ready patterns per scenario
    always @(negedge clk) begin
        cyc++;
        case (mode)
            0: begin bus_rdy = 1'b1; str_rdy = 1'b1; end
            1: begin
                bus_rdy = 1'b1;
                if (beats == 1 && hold < 5) begin str_rdy = 1'b0; hold++; end
                else str_rdy = 1'b1;
            end
            2: begin bus_rdy = (cyc % 3 == 0); str_rdy = 1'b1; end
            default: begin
                bus_rdy = ($urandom_range(2) != 0);
                str_rdy = ($urandom_range(3) != 0);
            end
        endcase
    end

    // memory responder: data for a handshake is driven in the following cycle
    always @(posedge clk) begin
        #1;
        bus_rdt = pend ? mem_at(pend_adr) : DW'($urandom);
    end

    always @(negedge clk) begin
        #1;
        if (rst) begin
            if (prev_bstall) begin
                chk("bus_vld_hold", 64'(bus_vld), 1);
                chk("bus_adr_hold", 64'(bus_adr), 64'(prev_badr));
            end
            chk("occupancy_bound", 64'(hs_total - beats_total <= FD), 1);
            if (hs_total - beats_total >= FD) chk("bus_vld_when_full", 64'(bus_vld), 0);
            if (bus_vld) begin
                chk("bus_wen", 64'(bus_wen), 0);
                chk("bus_ben", 64'(bus_ben), 64'hF);
                chk("bus_wdt", 64'(bus_wdt), 0);
                bvld_cnt++;
                if (bus_rdy) hs_total++;
            end
        end
        pend        = rst && bus_vld && bus_rdy;
        pend_adr    = bus_adr;
        prev_bstall = rst && bus_vld && !bus_rdy;
        prev_badr   = bus_adr;
    end

    // stream monitor: pops the scoreboard on each beat
    always @(negedge clk) begin
        #2;
        if (rst) begin
            if (done || err) chk("done_err_exclusive", 64'(done && err), 0);
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (prev_sstall) begin
                chk("str_vld_hold", 64'(str_vld), 1);
                chk("str_word_hold", 64'({str_lst, str_dat}), 64'(prev_sword));
            end
            if (str_vld) svld_cnt++;
            if (str_vld && str_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL stream_extra: got %0h expected no beat", str_dat);
                end else begin
                    ex = exp_q.pop_front();
                    chk("str_dat", 64'(str_dat), 64'(ex[DW-1:0]));
                    chk("str_lst", 64'(str_lst), 64'(ex[DW]));
                end
                if (beats == 0) first_cyc = cyc;
                last_cyc = cyc;
                beats++;
                beats_total++;
            end
        end
        prev_sstall = rst && str_vld && !str_rdy;
        prev_sword  = {str_lst, str_dat};
    end

    task automatic run_range(input int b, input int e, input int md, input bit restart);
        int  n, t, d0, e0, b0, s0;
        bit  bad;
        mode = md;
        hold = 0;
        beats = 0;
        d0 = done_cnt; e0 = err_cnt; b0 = bvld_cnt; s0 = svld_cnt;
        bad = (b % BW != 0) || (e % BW != 0) || (e < b);
        n = bad ? 0 : (e - b) / BW;
        @(negedge clk);
        cfg_beg = AW'(b);
        cfg_end = AW'(e);
        start = 1'b1;
        for (int a = b; a < e && !bad; a += BW)
            exp_q.push_back({a == e - BW, mem_at(AW'(a))});
        @(negedge clk);
        start = 1'b0;
        #3;
        chk("err_after_start", 64'(err), 64'(bad));
        chk("done_after_start", 64'(done), 64'(!bad && n == 0));
        chk("busy_after_start", 64'(busy), 64'(n > 0));
        if (restart && n > 0) begin
            repeat (2) @(negedge clk);
            cfg_beg = AW'(32'h300);
            cfg_end = AW'(32'h340);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        t = 0;
        while (n > 0 && done_cnt == d0 && t < 300) begin
            @(negedge clk);
            #3;
            t++;
        end
        chk("run_timeout", 64'(t < 300), 1);
        repeat (3) @(negedge clk);
        #3;
        chk("beat_count", 64'(beats), 64'(n));
        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        chk("done_pulses", 64'(done_cnt - d0), 64'(!bad));
        chk("err_pulses", 64'(err_cnt - e0), 64'(bad));
        chk("idle_after", 64'(busy), 0);
        if (n == 0) begin
            chk("no_bus_vld", 64'(bvld_cnt - b0), 0);
            chk("no_str_vld", 64'(svld_cnt - s0), 0);
        end
        if (md == 0 && n > 0) chk("throughput", 64'(last_cyc - first_cyc), 64'(n - 1));
        exp_q.delete();
    endtask

    initial begin
        #2 rst = 1'b0;
        #1 chk_reset("reset_async");
        repeat (2) @(negedge clk);
        chk_reset("reset_hold");
        rst = 1'b1;

        run_range(32'h100, 32'h110, 0, 1'b0);
        run_range(32'h100, 32'h110, 1, 1'b0);
        run_range(32'h100, 32'h110, 2, 1'b0);
        run_range(32'h200, 32'h200, 0, 1'b0);
        run_range(32'h204, 32'h200, 0, 1'b0);
        run_range(32'h101, 32'h110, 0, 1'b0);
        run_range(32'h100, 32'h10A, 0, 1'b0);

        begin
            int t;
            mode = 0;
            beats = 0;
            @(negedge clk);
            cfg_beg = AW'(32'h100);
            cfg_end = AW'(32'h110);
            start = 1'b1;
            for (int a = 32'h100; a < 32'h110; a += BW)
                exp_q.push_back({a == 32'h10C, mem_at(AW'(a))});
            @(negedge clk);
            start = 1'b0;
            t = 0;
            while (beats < 2 && t < 50) begin
                @(negedge clk);
                #3;
                t++;
            end
            chk("reset_test_timeout", 64'(t < 50), 1);
            rst = 1'b0;
            #1 chk_reset("reset_mid_read");
            exp_q.delete();
            hs_total = 0;
            beats_total = 0;
            repeat (2) @(negedge clk);
            rst = 1'b1;
        end
        run_range(32'h100, 32'h108, 0, 1'b0);

        run_range(32'h100, 32'h110, 1, 1'b1);

        for (int i = 0; i < 25; i++) begin
            int b, e, k;
            b = 32'h400 + BW * int'($urandom_range(32));
            e = b + BW * int'($urandom_range(6));
            k = int'($urandom_range(7));
            if (k == 0) e = e + 2;
            else if (k == 1) b = b + 1;
            else if (k == 2 && e > b) begin int s; s = b; b = e; e = s; end
            run_range(b, e, 3, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
